pswitch_merger: RTL and testbench



---
 rtl/pswitch_merger.sv | 174 +++++++++++++++++
 tb/tb_pswitch_merger.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pswitch_merger.sv
// rtl/pswitch_merger.sv - packet-granular 2:1 AXI-Stream merger (agg + bypass) with per-source packet counters
// Each source is buffered in a fall-through FIFO; whole packets are granted round-robin.

module pswitch_merger_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             nearly_full
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] NF_LEVEL = (DEPTH_BITS+1)'(DEPTH - 1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;

  // Head word is read straight out of the array so it is visible the cycle after the write.
  assign rd_data     = mem[rd_ptr];
  assign empty       = (count == '0);
  assign nearly_full = (count >= NF_LEVEL);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      if (rd_en) rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      if (wr_en && !rd_en)      count <= count + (DEPTH_BITS+1)'(1);
      else if (!wr_en && rd_en) count <= count - (DEPTH_BITS+1)'(1);
    end
  end
endmodule

module pswitch_merger #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 6,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                              axis_aclk,
  input  logic                              axis_reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_agg_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_agg_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_agg_tuser,
  input  logic                              s_axis_agg_tvalid,
  output logic                              s_axis_agg_tready,
  input  logic                              s_axis_agg_tlast,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_oq_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_oq_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_oq_tuser,
  input  logic                              s_axis_oq_tvalid,
  output logic                              s_axis_oq_tready,
  input  logic                              s_axis_oq_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,

  input  logic                              clear_counters,
  output logic [CNT_WIDTH-1:0]              pkt_out_agg,
  output logic [CNT_WIDTH-1:0]              pkt_out_oq
);
  localparam int WORD_W = 1 + C_M_AXIS_TUSER_WIDTH + C_M_AXIS_DATA_WIDTH/8 + C_M_AXIS_DATA_WIDTH;
  localparam logic SRC_AGG = 1'b0;
  localparam logic SRC_OQ  = 1'b1;

  typedef enum logic {ARB, SEND} state_t;

  state_t            state;
  logic              grant;
  logic              last_grant;
  logic [WORD_W-1:0] agg_head;
  logic [WORD_W-1:0] oq_head;
  logic [WORD_W-1:0] head;
  logic              agg_empty;
  logic              oq_empty;
  logic              agg_nearly_full;
  logic              oq_nearly_full;
  logic              head_empty;
  logic              agg_pop;
  logic              oq_pop;
  logic              m_fire;
  logic              arb_pick;

  assign s_axis_agg_tready = ~agg_nearly_full;
  assign s_axis_oq_tready  = ~oq_nearly_full;

  pswitch_merger_fifo #(.WIDTH(WORD_W), .DEPTH_BITS(FIFO_DEPTH_BITS)) agg_fifo (
    .clk         (axis_aclk),
    .reset       (axis_reset),
    .wr_data     ({s_axis_agg_tlast, s_axis_agg_tuser, s_axis_agg_tkeep, s_axis_agg_tdata}),
    .wr_en       (s_axis_agg_tvalid & s_axis_agg_tready),
    .rd_en       (agg_pop),
    .rd_data     (agg_head),
    .empty       (agg_empty),
    .nearly_full (agg_nearly_full)
  );

  pswitch_merger_fifo #(.WIDTH(WORD_W), .DEPTH_BITS(FIFO_DEPTH_BITS)) oq_fifo (
    .clk         (axis_aclk),
    .reset       (axis_reset),
    .wr_data     ({s_axis_oq_tlast, s_axis_oq_tuser, s_axis_oq_tkeep, s_axis_oq_tdata}),
    .wr_en       (s_axis_oq_tvalid & s_axis_oq_tready),
    .rd_en       (oq_pop),
    .rd_data     (oq_head),
    .empty       (oq_empty),
    .nearly_full (oq_nearly_full)
  );

  assign head       = (grant == SRC_OQ) ? oq_head : agg_head;
  assign head_empty = (grant == SRC_OQ) ? oq_empty : agg_empty;

  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = head;
  assign m_axis_tvalid = (state == SEND) && !head_empty;
  assign m_fire        = m_axis_tvalid && m_axis_tready;
  assign agg_pop       = m_fire && (grant == SRC_AGG);
  assign oq_pop        = m_fire && (grant == SRC_OQ);

  // On a tie the source that did not win last time goes next; otherwise the only non-empty one.
  assign arb_pick = (!agg_empty && !oq_empty) ? ~last_grant : agg_empty;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state      <= ARB;
      grant      <= SRC_AGG;
      last_grant <= SRC_OQ;
    end else begin
      case (state)
        ARB: begin
          if (!agg_empty || !oq_empty) begin
            grant      <= arb_pick;
            last_grant <= arb_pick;
            state      <= SEND;
          end
        end
        SEND: begin
          if (m_fire && m_axis_tlast) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset || clear_counters) begin
      pkt_out_agg <= '0;
      pkt_out_oq  <= '0;
    end else if (m_fire && m_axis_tlast) begin
      if (grant == SRC_OQ) pkt_out_oq  <= pkt_out_oq + CNT_WIDTH'(1);
      else                 pkt_out_agg <= pkt_out_agg + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_pswitch_merger.sv
// tb/tb_pswitch_merger.sv - self-checking bench for pswitch_merger
// Beats carry a 16-bit tag {src, pkt id, beat} replicated across tdata/tuser/tkeep.

module tb_pswitch_merger;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_agg_tdata, s_oq_tdata, m_tdata;
  logic [KW-1:0] s_agg_tkeep, s_oq_tkeep, m_tkeep;
  logic [UW-1:0] s_agg_tuser, s_oq_tuser, m_tuser;
  logic          s_agg_tvalid, s_agg_tready, s_agg_tlast;
  logic          s_oq_tvalid, s_oq_tready, s_oq_tlast;
  logic          m_tvalid, m_tready, m_tlast;
  logic          clear_counters;
  logic [CW-1:0] pkt_out_agg, pkt_out_oq;

  always #5 clk = ~clk;

  pswitch_merger dut (
    .axis_aclk         (clk),
    .axis_reset        (rst),
    .s_axis_agg_tdata  (s_agg_tdata),
    .s_axis_agg_tkeep  (s_agg_tkeep),
    .s_axis_agg_tuser  (s_agg_tuser),
    .s_axis_agg_tvalid (s_agg_tvalid),
    .s_axis_agg_tready (s_agg_tready),
    .s_axis_agg_tlast  (s_agg_tlast),
    .s_axis_oq_tdata   (s_oq_tdata),
    .s_axis_oq_tkeep   (s_oq_tkeep),
    .s_axis_oq_tuser   (s_oq_tuser),
    .s_axis_oq_tvalid  (s_oq_tvalid),
    .s_axis_oq_tready  (s_oq_tready),
    .s_axis_oq_tlast   (s_oq_tlast),
    .m_axis_tdata      (m_tdata),
    .m_axis_tkeep      (m_tkeep),
    .m_axis_tuser      (m_tuser),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .m_axis_tlast      (m_tlast),
    .clear_counters    (clear_counters),
    .pkt_out_agg       (pkt_out_agg),
    .pkt_out_oq        (pkt_out_oq)
  );

  typedef struct {
    logic [15:0] tag;
    logic        last;
    int          cyc;
  } beat_t;

  typedef struct {
    int         a0, a1, o0, o1;
    int         npk;
    logic [7:0] order;
    int         cnt_agg, cnt_oq;
  } scen_t;

  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;
  int          total_in;
  int          first_cyc [2];
  beat_t       out_q[$];
  beat_t       exp_agg[$];
  beat_t       exp_oq[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_tag;
  bit          rand_run;
  event        ev_b1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_tag(input int src, input int id, input int b);
    return {src[0], id[6:0], b[7:0]};
  endfunction

  // Output monitor: records every handshake and checks stall stability and sideband pass-through.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata[15:0], prev_tag);
      end
      if (m_tvalid && m_tready) begin
        check("passthrough", {m_tdata == {16{m_tdata[15:0]}},
                              m_tuser == {8{m_tdata[15:0] ^ 16'hA5A5}},
                              m_tkeep == {2{m_tdata[15:0]}}}, 3'b111);
        out_q.push_back('{m_tdata[15:0], m_tlast, cycle});
      end
      prev_stall = m_tvalid && !m_tready;
      prev_tag   = m_tdata[15:0];
    end
  end

  task automatic drive_beat(input int src, input logic [15:0] tag, input logic last);
    int n = 0;
    if (src == 0) begin
      s_agg_tdata = {16{tag}}; s_agg_tuser = {8{tag ^ 16'hA5A5}};
      s_agg_tkeep = {2{tag}};  s_agg_tlast = last; s_agg_tvalid = 1'b1;
    end else begin
      s_oq_tdata = {16{tag}}; s_oq_tuser = {8{tag ^ 16'hA5A5}};
      s_oq_tkeep = {2{tag}};  s_oq_tlast = last; s_oq_tvalid = 1'b1;
    end
    forever begin
      @(negedge clk);
      if ((src == 0) ? s_agg_tready : s_oq_tready) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL input_timeout: src %0d tag %0h never accepted, required acceptance", src, tag);
        break;
      end
    end
    if (n <= 500) begin
      if (tag[7:0] == 8'd0) first_cyc[src] = cycle;
      if (src == 0) exp_agg.push_back('{tag, last, cycle});
      else          exp_oq.push_back('{tag, last, cycle});
      total_in++;
    end
    @(posedge clk); #1;
    if (src == 0) s_agg_tvalid = 1'b0; else s_oq_tvalid = 1'b0;
  endtask

  task automatic drive_pkt(input int src, input int id, input int len, input int gap);
    for (int b = 0; b < len; b++) drive_beat(src, mk_tag(src, id, b), b == len - 1);
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; clear_counters = 1'b0; s_agg_tvalid = 1'b0; s_oq_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_q.delete(); exp_agg.delete(); exp_oq.delete(); total_in = 0;
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, out_q.size() >= n, 1);
  endtask

  // Scoreboard: each output packet must come wholly from one source, in that source's input order.
  task automatic verify_order(output logic [7:0] ord, output int npk);
    int    cur = -1;
    beat_t e;
    ord = '0;
    npk = 0;
    foreach (out_q[i]) begin
      int s = int'(out_q[i].tag[15]);
      if (cur < 0) begin
        cur = s;
        if (npk < 8) ord[npk] = s[0];
      end else begin
        check("no_interleave", s, cur);
      end
      if ((s == 0 && exp_agg.size() == 0) || (s == 1 && exp_oq.size() == 0)) begin
        checks++; errors++;
        $display("FAIL extra_beat: got tag %0h, required no beat", out_q[i].tag);
      end else begin
        if (s == 0) e = exp_agg.pop_front();
        else        e = exp_oq.pop_front();
        check("beat_tag", out_q[i].tag, e.tag);
        check("beat_last", out_q[i].last, e.last);
      end
      if (out_q[i].last) begin
        cur = -1;
        npk++;
      end
    end
    check("missing_beats", exp_agg.size() + exp_oq.size(), 0);
  endtask

  scen_t       scen [5];
  logic [7:0]  ord;
  int          npk;
  int          n_pkts;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear_counters = 1'b0; m_tready = 1'b1;
    s_agg_tvalid = 1'b0; s_agg_tlast = 1'b0; s_agg_tdata = '0; s_agg_tkeep = '0; s_agg_tuser = '0;
    s_oq_tvalid  = 1'b0; s_oq_tlast  = 1'b0; s_oq_tdata  = '0; s_oq_tkeep  = '0; s_oq_tuser  = '0;

    // order bit i = source of the i-th output packet (1 = oq); agg wins the first tie after reset.
    scen[0] = '{3, 0, 0, 0, 1, 8'b0000_0000, 1, 0};
    scen[1] = '{2, 2, 2, 2, 4, 8'b0000_1010, 2, 2};
    scen[2] = '{0, 0, 1, 0, 1, 8'b0000_0001, 0, 1};
    scen[3] = '{1, 0, 3, 1, 3, 8'b0000_0110, 1, 2};
    scen[4] = '{4, 1, 1, 0, 3, 8'b0000_0010, 2, 1};

    do_reset();
    @(negedge clk);
    check("reset_tvalid", m_tvalid, 0);
    check("reset_agg_tready", s_agg_tready, 1);
    check("reset_oq_tready", s_oq_tready, 1);
    check("reset_cnt_agg", pkt_out_agg, 0);
    check("reset_cnt_oq", pkt_out_oq, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      m_tready = 1'b1;
      fork
        begin
          if (scen[i].a0 > 0) drive_pkt(0, 0, scen[i].a0, 0);
          if (scen[i].a1 > 0) drive_pkt(0, 1, scen[i].a1, 0);
        end
        begin
          if (scen[i].o0 > 0) drive_pkt(1, 0, scen[i].o0, 0);
          if (scen[i].o1 > 0) drive_pkt(1, 1, scen[i].o1, 0);
        end
      join
      wait_out(scen[i].a0 + scen[i].a1 + scen[i].o0 + scen[i].o1, 100, "scen_timeout");
      repeat (4) @(posedge clk);
      #1;
      if (i == 0) begin
        for (int k = 0; k < 3; k++)
          if (k < out_q.size()) check("latency_single", out_q[k].cyc, first_cyc[0] + 2 + k);
      end
      verify_order(ord, npk);
      check("scen_npk", npk, scen[i].npk);
      check("scen_order", ord, scen[i].order);
      check("scen_cnt_agg", pkt_out_agg, scen[i].cnt_agg);
      check("scen_cnt_oq", pkt_out_oq, scen[i].cnt_oq);
    end

    // Backpressure: 63 stored entries deassert tready; nothing lost once the output drains.
    do_reset();
    m_tready = 1'b0;
    for (int b = 0; b < 63; b++) drive_beat(1, mk_tag(1, 0, b), 1'b0);
    @(negedge clk);
    check("bp_tready_low", s_oq_tready, 0);
    check("bp_tvalid_held", m_tvalid, 1);
    @(posedge clk); #1;
    fork
      drive_beat(1, mk_tag(1, 0, 63), 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    wait_out(64, 300, "bp_timeout");
    repeat (3) @(posedge clk);
    #1;
    verify_order(ord, npk);
    check("bp_npk", npk, 1);
    check("bp_cnt_oq", pkt_out_oq, 1);

    // Mid-packet starvation: agg stalls after beat 0 while an oq packet waits.
    do_reset();
    m_tready = 1'b1;
    fork
      begin
        drive_beat(0, mk_tag(0, 0, 0), 1'b0);
        -> ev_b1;
        repeat (5) @(posedge clk);
        #1;
        drive_beat(0, mk_tag(0, 0, 1), 1'b0);
        drive_beat(0, mk_tag(0, 0, 2), 1'b1);
      end
      drive_pkt(1, 0, 2, 0);
      begin
        @(ev_b1);
        @(posedge clk);
        @(posedge clk);
        repeat (4) begin
          @(negedge clk);
          check("starve_tvalid_low", m_tvalid, 0);
          @(posedge clk);
        end
      end
    join
    wait_out(5, 100, "starve_timeout");
    repeat (3) @(posedge clk);
    #1;
    verify_order(ord, npk);
    check("starve_order", ord, 8'b0000_0010);
    check("starve_npk", npk, 2);

    // Counter wrap, then clear colliding with a tlast handshake.
    do_reset();
    m_tready = 1'b1;
    force dut.pkt_out_oq = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.pkt_out_oq;
    @(posedge clk); #1;
    check("cnt_preload", pkt_out_oq, 32'hFFFF_FFFF);
    drive_pkt(1, 0, 1, 0);
    wait_out(1, 50, "wrap_timeout");
    repeat (2) @(posedge clk);
    #1;
    check("cnt_wrap_oq", pkt_out_oq, 0);
    check("cnt_wrap_agg", pkt_out_agg, 0);
    drive_pkt(0, 0, 1, 0);
    wait_out(2, 50, "agg1_timeout");
    repeat (2) @(posedge clk);
    #1;
    check("cnt_agg_one", pkt_out_agg, 1);
    m_tready = 1'b0;
    drive_pkt(0, 1, 1, 0);
    begin
      int k = 0;
      while (!m_tvalid && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      check("clr_tvalid_wait", m_tvalid, 1);
    end
    clear_counters = 1'b1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    clear_counters = 1'b0;
    check("clr_handshake_seen", out_q.size(), 3);
    check("clr_priority_agg", pkt_out_agg, 0);
    check("clr_priority_oq", pkt_out_oq, 0);

    // Reset in the middle of a 4-beat packet.
    do_reset();
    m_tready = 1'b1;
    fork
      drive_pkt(0, 0, 4, 0);
      begin
        int k = 0;
        while (out_q.size() < 1 && k < 50) begin
          @(posedge clk); #1;
          k++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    @(negedge clk);
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_cnt_agg", pkt_out_agg, 0);
    check("rst_mid_cnt_oq", pkt_out_oq, 0);
    check("rst_mid_tready", {s_agg_tready, s_oq_tready}, 2'b11);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_flushed", m_tvalid, 0);
    end
    @(posedge clk); #1;
    out_q.delete(); exp_agg.delete(); exp_oq.delete(); total_in = 0;
    drive_pkt(1, 5, 1, 0);
    wait_out(1, 50, "rst_mid_timeout");
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_latency", out_q.size() > 0 ? out_q[0].cyc : -1, first_cyc[1] + 2);
    verify_order(ord, npk);
    check("rst_mid_npk", npk, 1);
    check("rst_mid_cnt_after", pkt_out_oq, 1);

    // Random traffic on both sources with random output backpressure.
    do_reset();
    n_pkts = 25;
    rand_run = 1'b1;
    fork
      begin
        fork
          for (int p = 0; p < n_pkts; p++)
            drive_pkt(0, p, $urandom_range(1, 12), $urandom_range(0, 3));
          for (int p = 0; p < n_pkts; p++)
            drive_pkt(1, p, $urandom_range(1, 12), $urandom_range(0, 3));
        join
        wait_out(total_in, 2000, "rand_timeout");
        rand_run = 1'b0;
      end
      while (rand_run) begin
        @(posedge clk); #1;
        m_tready = ($urandom_range(0, 2) != 0);
      end
    join
    m_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    verify_order(ord, npk);
    check("rand_npk", npk, 2 * n_pkts);
    check("rand_cnt_agg", pkt_out_agg, n_pkts);
    check("rand_cnt_oq", pkt_out_oq, n_pkts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
